// File: rtl/dh_enc_check_seq.sv
// Iterative Diffie-Hellman round-1 check: shift-subtract reduction of exp mod p,
// followed by the challenge compare that produces the response nibble c2.
module dh_enc_check_seq #(
  parameter int EXP_W = 64,
  parameter int P_W   = 32,
  parameter int C_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [EXP_W-1:0] exp,
  input  logic [P_W-1:0]   p,
  input  logic [C_W-1:0]   c1,
  input  logic [P_W-1:0]   r1,
  input  logic [P_W-1:0]   r2,
  output logic             busy,
  output logic             done,
  output logic             true,
  output logic             err,
  output logic [C_W-1:0]   c2,
  output logic [P_W-1:0]   rem_o
);

  localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {IDLE, REDUCE, CHECK, FAULT} state_t;

  state_t             state_q, state_d;
  logic [P_W:0]       r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [P_W-1:0]     p_q, p_d;
  logic [C_W-1:0]     c1_q, c1_d;
  logic [P_W-1:0]     r1_q, r1_d;
  logic [P_W-1:0]     r2_q, r2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               true_q, true_d;
  logic               err_q, err_d;
  logic [C_W-1:0]     c2_q, c2_d;
  logic [P_W-1:0]     rem_q, rem_d;

  logic [P_W:0]       r_shift;
  logic [C_W-1:0]     k;
  logic [P_W-1:0]     r2_new;
  logic               accept;

  // clr beats start in IDLE, so a simultaneous request is dropped
  assign accept = start && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (p == '0) ? FAULT : REDUCE;
        end
      end
      REDUCE: begin
        if (clr) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = CHECK;
        end
      end
      CHECK:   state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d     = r_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    p_d     = p_q;
    c1_d    = c1_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    true_d  = true_q;
    err_d   = err_q;
    c2_d    = c2_q;
    rem_d   = rem_q;
    r_shift = {r_q[P_W-1:0], exp_q[cnt_q]};
    k       = r_q[C_W-1:0];
    r2_new  = P_W'(k ^ c1_q);
    case (state_q)
      IDLE: begin
        if (accept) begin
          exp_d  = exp;
          p_d    = p;
          c1_d   = c1;
          r1_d   = r1;
          r2_d   = r2;
          r_d    = '0;
          cnt_d  = CNT_W'(EXP_W - 1);
          busy_d = 1'b1;
        end
      end
      REDUCE: begin
        if (clr) begin
          busy_d = 1'b0;
        end else begin
          // R stays below p, so the shifted value is below 2p and fits P_W+1 bits
          if (r_shift >= {1'b0, p_q}) begin
            r_d = r_shift - {1'b0, p_q};
          end else begin
            r_d = r_shift;
          end
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        busy_d = 1'b0;
        if (!clr) begin
          if (r2_new == r2_q) begin
            c2_d   = k ^ r1_q[C_W-1:0];
            true_d = 1'b1;
          end else begin
            c2_d   = '0;
            true_d = 1'b0;
          end
          err_d  = 1'b0;
          rem_d  = r_q[P_W-1:0];
          done_d = 1'b1;
        end
      end
      FAULT: begin
        busy_d = 1'b0;
        if (!clr) begin
          c2_d   = '0;
          true_d = 1'b0;
          err_d  = 1'b1;
          rem_d  = '0;
          done_d = 1'b1;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      cnt_q  <= '0;
      exp_q  <= '0;
      p_q    <= '0;
      c1_q   <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      true_q <= 1'b0;
      err_q  <= 1'b0;
      c2_q   <= '1;
      rem_q  <= '0;
    end else begin
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      exp_q  <= exp_d;
      p_q    <= p_d;
      c1_q   <= c1_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      busy_q <= busy_d;
      done_q <= done_d;
      true_q <= true_d;
      err_q  <= err_d;
      c2_q   <= c2_d;
      rem_q  <= rem_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign true  = true_q;
  assign err   = err_q;
  assign c2    = c2_q;
  assign rem_o = rem_q;

endmodule

// File: doc/dh_enc_check_seq.md
Name: dh_enc_check_seq

Overview:
Sequential controller for the Diffie-Hellman round-1 check step. It replaces the single-cycle divide/multiply with an iterative shift-subtract reduction of exp mod p. It then runs the challenge compare (k ^ c1 vs r2) and produces the response nibble c2. It sits between the key-exchange top FSM, which issues start, and the round-2 encryption stage, which consumes done/true/c2.

Parameters:
EXP_W, 64, width of exponent result being reduced
P_W, 32, width of modulus p, of r1/r2 and of the remainder
C_W, 4, width of challenge c1, of response c2 and of key nibble k

Ports:
clk      in   1      system clock, rising edge
rst      in   1      asynchronous reset, active-high
start    in   1      one-cycle request; sampled only in IDLE
clr      in   1      synchronous abort; returns to IDLE, outputs held
exp      in   EXP_W  value to reduce; captured on accepted start
p        in   P_W    modulus; captured on accepted start
c1       in   C_W    challenge; captured on accepted start
r1       in   P_W    local secret; captured on accepted start
r2       in   P_W    expected peer value; captured on accepted start
busy     out  1      high from the accepting edge until done
done     out  1      one-cycle pulse when results are valid
true     out  1      challenge matched (held until next done)
err      out  1      p was zero (held until next done)
c2       out  C_W    response nibble (held until next done)
rem_o    out  P_W    full remainder exp mod p (held until next done)

Behaviour:
- Reset (rst=1, async): state=IDLE, c2=all ones (4'hF), true=0, err=0, done=0, busy=0, rem_o=0. The internal remainder, counter and captured operands are cleared.
- States: IDLE, REDUCE, CHECK, FAULT.
- IDLE: on start=1, capture all inputs, set R=0 (P_W+1 bits), cnt=EXP_W-1 and busy=1.
  - If p==0, go to FAULT.
  - Otherwise go to REDUCE.
- REDUCE, one exponent bit per cycle, MSB first:
  - R' = {R[P_W-1:0], exp_q[cnt]}.
  - If R' >= {1'b0,p_q}, then R = R' - p_q; else R = R'.
  - Decrement cnt. After the cnt==0 iteration, go to CHECK.
  - The result is exactly exp mod p for all p>=1, including p > exp (remainder = exp).
- CHECK, single cycle:
  - k = R[C_W-1:0] (truncated, as in the existing round-1 datapath).
  - r2_new = zero-extended (k ^ c1_q).
  - If r2_new == r2_q (full P_W compare): c2 = k ^ r1_q[C_W-1:0], true=1.
  - Else: c2=0, true=0.
  - In both cases: err=0, rem_o=R[P_W-1:0], done=1, busy=0, go to IDLE.
- FAULT, single cycle: c2=0, true=0, err=1, rem_o=0, done=1, busy=0, go to IDLE.
- Latency:
  - Normal path: done asserts in the cycle following the (EXP_W+1)th rising edge after the start-sampling edge, i.e. 65 edges at defaults.
  - p==0 path: done follows 1 edge.
- done is high exactly one cycle. Outputs change only on done or reset.
- start while busy is ignored; there is no queueing.
- start and done in the same cycle: not possible, since start is sampled in IDLE only. A start in the cycle after done is accepted.
- clr=1 in any non-IDLE state: go to IDLE next edge, busy=0, no done. c2/true/err/rem_o keep their previous values.
- clr in IDLE: no effect. clr and start together in IDLE: clr wins, start is dropped.
- Reset mid-operation: immediate return to reset values; no done is produced. After rst falls, the next start runs normally.
- Input changes after capture have no effect on the running operation.

Test Plan:
- exp=100, p=7, c1=3, r1=5, r2=1, start pulse -> done at edge 65; rem_o=2, true=1, c2=7, err=0, busy high during edges 1..64.
- Same operands with r2=2 -> rem_o=2, true=0, c2=0.
- exp=64'hFFFF_FFFF_FFFF_FFFF, p=32'hFFFF_FFFF, c1=0, r2=0, r1=32'hA -> rem_o=0, true=1, c2=4'hA (wrap / large-operand boundary).
- exp=5, p=11, c1=0, r2=5, r1=0 -> rem_o=5, true=1, c2=5. Then p=0 -> done after 1 edge, err=1, true=0, c2=0.
- Second start at edge 10 of a run -> ignored, single done at edge 65. clr at edge 20 of another run -> busy drops, no done, outputs hold the prior results.
- rst asserted at edge 30 mid-run -> c2=4'hF, true=0, err=0, busy=0 immediately. A fresh start after release completes correctly with the first test's values.
